// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin presentation over a valid/ready port.
// Define EDGE_ARB_OVF_EN to build the sticky per-channel lost-edge (ovf) flags.
module edge_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH*W-1:0]       in_ch,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_CH)-1:0] evt_ch,
    output logic [W-1:0]              evt_bits,
    output logic [NUM_CH-1:0]         ovf,
    input  logic [NUM_CH-1:0]         ovf_clr
);

    localparam int CW = $clog2(NUM_CH);

    // Handshake: an event transfers on a rising edge where evt_valid && evt_ready;
    // while evt_valid is high and evt_ready low, evt_ch/evt_bits hold stable.
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                   state_q;
    logic                     evt_valid_q;
    logic [CW-1:0]            evt_ch_q;
    logic [W-1:0]             evt_bits_q;
    logic [CW-1:0]            last_grant_q;
    logic                     armed_q;

    logic [NUM_CH-1:0][W-1:0] in_arr;
    logic [NUM_CH-1:0][W-1:0] prev_q;
    logic [NUM_CH-1:0][W-1:0] edges;
    logic [NUM_CH-1:0][W-1:0] pending_q;
    logic [NUM_CH-1:0][W-1:0] pending_d;

    logic                     any_pending;
    logic [CW-1:0]            grant_ch;
    logic [CW-1:0]            cand;
    logic                     grant_fire;

    assign in_arr = in_ch;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            edges[k] = armed_q ? (in_arr[k] & ~prev_q[k]) : '0;
        end
    end

    // Round-robin: the first non-empty channel after the last grant wins.
    always_comb begin
        any_pending = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CW'((int'(last_grant_q) + i) % NUM_CH);
            if (!any_pending && (pending_q[cand] != '0)) begin
                any_pending = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign grant_fire = any_pending && ((state_q == IDLE) || evt_ready);

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            pending_d[k] = pending_q[k] | edges[k];
            if (grant_fire && (grant_ch == CW'(k))) begin
                pending_d[k] = edges[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            prev_q    <= in_arr;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_ch_q     <= '0;
            evt_bits_q   <= '0;
            last_grant_q <= CW'(NUM_CH - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        state_q      <= PRESENT;
                        evt_valid_q  <= 1'b1;
                        evt_ch_q     <= grant_ch;
                        evt_bits_q   <= pending_q[grant_ch];
                        last_grant_q <= grant_ch;
                    end
                end
                PRESENT: begin
                    if (grant_fire) begin
                        evt_ch_q     <= grant_ch;
                        evt_bits_q   <= pending_q[grant_ch];
                        last_grant_q <= grant_ch;
                    end else if (evt_ready) begin
                        state_q     <= IDLE;
                        evt_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_bits  = evt_bits_q;

`ifdef EDGE_ARB_OVF_EN
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] ovf_d;

    // A bit being granted this cycle moves to evt_bits, so its new edge is not lost.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ovf_set[k] = (|(edges[k] & pending_q[k])) &&
                         !(grant_fire && (grant_ch == CW'(k)));
        end
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ^ovf_clr;
    assign ovf            = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NUM_CH=4, W=8); honours EDGE_ARB_OVF_EN.
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int W      = 8;

    logic                clk;
    logic                rst_n;
    logic [NUM_CH*W-1:0] in_ch;
    logic                evt_valid;
    logic                evt_ready;
    logic [1:0]          evt_ch;
    logic [W-1:0]        evt_bits;
    logic [NUM_CH-1:0]   ovf;
    logic [NUM_CH-1:0]   ovf_clr;

    int n_cmp;
    int n_err;

    edge_event_arbiter #(.NUM_CH(NUM_CH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ch     (in_ch),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_bits  (evt_bits),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_ch     = {NUM_CH{8'hFF}};
        evt_ready = 1'b0;
        ovf_clr   = '0;
        tick();
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
        n_cmp++;
        if (evt_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", evt_ch); end
        n_cmp++;
        if (evt_bits !== 8'h00) begin n_err++; $display("FAIL reset_bits: got %h want 00", evt_bits); end
        n_cmp++;
        if (ovf !== 4'h0) begin n_err++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (evt_valid !== 1'b0) begin n_err++; $display("FAIL armed_gate[%0d]: got valid %0b want 0", i, evt_valid); end
        end
        in_ch = '0;
        tick();
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL falling_only: got valid %0b want 0", evt_valid); end
    endtask

    task automatic test_single();
        evt_ready = 1'b1;
        in_ch     = {8'h00, 8'h00, 8'h00, 8'h05};
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_latency: got valid %0b want 0 at T", evt_valid); end
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd0, 8'h05}) begin
            n_err++; $display("FAIL single_event: got v=%0b ch=%0d bits=%h want v=1 ch=0 bits=05", evt_valid, evt_ch, evt_bits);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got valid %0b want 0", evt_valid); end
        in_ch = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b1;
        in_ch     = {8'h80, 8'h00, 8'h01, 8'h00};
        tick();
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd1, 8'h01}) begin
            n_err++; $display("FAIL b2b_first: got v=%0b ch=%0d bits=%h want v=1 ch=1 bits=01", evt_valid, evt_ch, evt_bits);
        end
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd3, 8'h80}) begin
            n_err++; $display("FAIL b2b_second: got v=%0b ch=%0d bits=%h want v=1 ch=3 bits=80", evt_valid, evt_ch, evt_bits);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got valid %0b want 0", evt_valid); end
        in_ch = '0;
        tick();
        in_ch = {8'h02, 8'h00, 8'h02, 8'h00};
        tick();
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd1, 8'h02}) begin
            n_err++; $display("FAIL rr_first: got v=%0b ch=%0d bits=%h want v=1 ch=1 bits=02", evt_valid, evt_ch, evt_bits);
        end
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd3, 8'h02}) begin
            n_err++; $display("FAIL rr_second: got v=%0b ch=%0d bits=%h want v=1 ch=3 bits=02", evt_valid, evt_ch, evt_bits);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle: got valid %0b want 0", evt_valid); end
        in_ch = '0;
        tick();
    endtask

    task automatic test_hold();
        evt_ready = 1'b0;
        in_ch     = {8'h00, 8'h01, 8'h00, 8'h00};
        tick();
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd2, 8'h01}) begin
            n_err++; $display("FAIL hold_first: got v=%0b ch=%0d bits=%h want v=1 ch=2 bits=01", evt_valid, evt_ch, evt_bits);
        end
        in_ch = {8'h00, 8'h11, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd2, 8'h01}) begin
                n_err++; $display("FAIL hold_stable[%0d]: got v=%0b ch=%0d bits=%h want v=1 ch=2 bits=01", i, evt_valid, evt_ch, evt_bits);
            end
        end
        evt_ready = 1'b1;
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd2, 8'h10}) begin
            n_err++; $display("FAIL hold_second: got v=%0b ch=%0d bits=%h want v=1 ch=2 bits=10", evt_valid, evt_ch, evt_bits);
        end
        tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL hold_idle: got valid %0b want 0", evt_valid); end
        in_ch = '0;
        tick();
    endtask

    task automatic test_ovf();
        logic [3:0] exp_set;
        logic [3:0] exp_clr;
`ifdef EDGE_ARB_OVF_EN
        exp_set = 4'b0001;
`else
        exp_set = 4'b0000;
`endif
        exp_clr   = 4'b0000;
        evt_ready = 1'b0;
        in_ch = {8'h00, 8'h00, 8'h00, 8'h01}; tick();
        in_ch = '0;                           tick();
        in_ch = {8'h00, 8'h00, 8'h00, 8'h01}; tick();
        n_cmp++;
        if (ovf !== 4'b0000) begin n_err++; $display("FAIL ovf_early: got %b want 0000", ovf); end
        in_ch = '0;                           tick();
        in_ch = {8'h00, 8'h00, 8'h00, 8'h01}; tick();
        n_cmp++;
        if (ovf !== exp_set) begin n_err++; $display("FAIL ovf_set: got %b want %b", ovf, exp_set); end
        ovf_clr = 4'b0001; tick();
        ovf_clr = 4'b0000;
        n_cmp++;
        if (ovf !== exp_clr) begin n_err++; $display("FAIL ovf_clear: got %b want %b", ovf, exp_clr); end
        in_ch = '0; tick();
        in_ch = {8'h00, 8'h00, 8'h00, 8'h01};
        ovf_clr = 4'b0001; tick();
        ovf_clr = 4'b0000;
        n_cmp++;
        if (ovf !== exp_set) begin n_err++; $display("FAIL ovf_set_wins: got %b want %b", ovf, exp_set); end
        ovf_clr = 4'b0001; tick();
        ovf_clr = 4'b0000;
        evt_ready = 1'b1;
        for (int i = 0; i < 8 && evt_valid; i++) tick();
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got valid %0b want 0 within 8 cycles", evt_valid); end
        in_ch = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        in_ch = {8'h00, 8'h00, 8'h04, 8'h00};
        tick();
        tick();
        n_cmp++;
        if ({evt_valid, evt_ch, evt_bits} !== {1'b1, 2'd1, 8'h04}) begin
            n_err++; $display("FAIL mid_present: got v=%0b ch=%0d bits=%h want v=1 ch=1 bits=04", evt_valid, evt_ch, evt_bits);
        end
        in_ch = {8'h00, 8'h08, 8'h04, 8'h00};
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_drop: got valid %0b want 0", evt_valid); end
        n_cmp++;
        if ({evt_ch, evt_bits} !== {2'd0, 8'h00}) begin n_err++; $display("FAIL mid_async_clear: got ch=%0d bits=%h want ch=0 bits=00", evt_ch, evt_bits); end
        tick();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale[%0d]: got valid %0b want 0", i, evt_valid); end
        end
        in_ch = '0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_ovf();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
